// File: rtl/udma_uart_rx_deser.sv
// uDMA UART receive deserializer: synchronizes rx_i, oversamples with the baud
// divider, assembles 5-8 bit frames and hands bytes out through a valid/ready register.
module udma_uart_rx_deser #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_i,
  input  logic        en_rx_i,
  input  logic [15:0] divider_i,
  input  logic [1:0]  num_bits_i,
  input  logic        parity_en_i,
  input  logic        stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_overflow_o,
  output logic        err_frame_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_rx;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  nbits_q, nbits_d;
  logic        par_en_q, par_en_d;
  logic        stop2_q, stop2_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_par_q, err_par_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_frm_q, err_frm_d;

  logic        tick;
  logic [2:0]  last_idx;
  logic        frame_done;
  logic        frame_err;

  assign s_rx     = sync_q[SYNC_STAGES-1];
  assign tick     = (cnt_q == div_q);
  assign last_idx = {1'b0, nbits_q} + 3'd4;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx_i};
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    data_d     = data_q;
    valid_d    = valid_q & ~rx_ready_i;
    err_par_d  = 1'b0;
    err_ovf_d  = 1'b0;
    err_frm_d  = 1'b0;
    frame_done = 1'b0;
    frame_err  = ferr_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_rx_i && !s_rx) begin
          div_d    = divider_i;
          nbits_d  = num_bits_i;
          par_en_d = parity_en_i;
          stop2_d  = stop_bits_i;
          // The detecting IDLE cycle is tick 0, so START begins at 1 and the
          // mid-bit sample lands div/2 cycles after the falling edge.
          cnt_d    = 16'd1;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == {1'b0, div_q[15:1]}) begin
          cnt_d = '0;
          if (s_rx) begin
            state_d = IDLE;
          end else begin
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            shift_d    = '0;
            par_d      = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            state_d    = DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = s_rx;
          par_d              = par_q ^ s_rx;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == last_idx) state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = par_q ^ s_rx;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (!s_rx) ferr_d = 1'b1;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d    = IDLE;
            frame_done = 1'b1;
            frame_err  = ferr_q | ~s_rx;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en_rx_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (frame_done) begin
      if (frame_err) begin
        err_frm_d = 1'b1;
      end else if (!valid_q || rx_ready_i) begin
        data_d    = shift_q;
        valid_d   = 1'b1;
        err_par_d = perr_q;
      end else begin
        err_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q     <= '1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      div_q      <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_par_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_frm_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_par_q  <= err_par_d;
      err_ovf_q  <= err_ovf_d;
      err_frm_q  <= err_frm_d;
    end
  end

  assign rx_data_o      = data_q;
  assign rx_valid_o     = valid_q;
  assign err_parity_o   = err_par_q;
  assign err_overflow_o = err_ovf_q;
  assign err_frame_o    = err_frm_q;
  assign busy_o         = (state_q != IDLE);

endmodule
